eth_pcs_rx_gearbox: RTL and testbench
=====================================

ETH_PCS_RX_GEARBOX -- requirements
Module: eth_pcs_rx_gearbox

Interface
REQ-001 SHALL have parameter: SLIP_HOLDOFF, default 4, o_valid blocks during which further slips are ignored (used only with ETH_PCS_RX_GEARBOX_SLIP_HOLDOFF_EN).
REQ-002 SHALL have port: i_clk  input  1  clock.
REQ-003 SHALL have port: i_reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: i_valid  input  1  i_data holds a new SerDes word this cycle.
REQ-005 SHALL have port: i_data  input  W_RX_WORD (32)  SerDes word; bit 0 is the earliest received bit.
REQ-006 SHALL have port: i_slip  input  1  discard one bit at the stream head, i.e. shift the block boundary by one bit.
REQ-007 SHALL have port: o_valid  output  1  o_sync_hdr/o_data hold a new 66-bit block.
REQ-008 SHALL have port: o_sync_hdr  output  W_SYNC (2)  block bits [1:0].
REQ-009 SHALL have port: o_data  output  64  block bits [65:2].

Function
REQ-010 SHALL hold received bits in a buffer of at least 97 bits plus a bit count cnt (0..97), with buffer bit 0 as the stream head.
REQ-011 SHALL, on each edge with i_valid=1, append i_data at buffer position cnt and add 32 to cnt.
REQ-012 SHALL, when cnt after the append is at least 66, register buffer[65:0] to the outputs, drive o_valid=1 for the next cycle only, shift the buffer down by 66 and subtract 66 from cnt.
REQ-013 SHALL give a latency of one clock from the edge that captures the completing input word to o_valid=1.
REQ-014 SHALL keep o_valid=0 in all other cycles.
REQ-015 SHALL keep o_sync_hdr/o_data stable while o_valid=0.
REQ-016 SHALL sample i_slip every cycle and honour it only when o_valid=1; i_slip with o_valid=0 is ignored.
REQ-017 SHALL allow i_slip to be combinationally derived from o_sync_hdr and o_valid; all outputs are registered.
REQ-018 SHALL, on an honoured slip, drop the head bit (shift by 1, cnt-1) at the same edge, after any append and extraction on that edge.
REQ-019 SHALL, when an honoured slip meets a residual cnt of 0, set slip_pending; the first bit of the next appended word is then discarded (append 31 bits) and slip_pending is cleared.
REQ-020 SHALL ignore a slip that arrives while slip_pending=1.
REQ-021 SHALL, in steady state with continuous i_valid and no slips, emit exactly 32 blocks per 66 input words.
REQ-022 SHALL leave buffer, cnt and slip_pending unchanged when i_valid=0 and no honoured slip occurs.

Reset
REQ-023 SHALL, with i_reset=1, clear buffer, cnt, slip_pending, the holdoff counter, o_valid, o_sync_hdr and o_data to 0 on the next edge, taking precedence over i_valid and i_slip, including mid-block; the first word after reset starts a new block at its bit 0.

Configuration
REQ-024 SHALL, with ETH_PCS_RX_GEARBOX_SLIP_HOLDOFF_EN defined, ignore i_slip after each honoured slip for the next SLIP_HOLDOFF o_valid blocks, tracked by a counter loaded on the slip and decremented per o_valid.
REQ-025 SHALL, without ETH_PCS_RX_GEARBOX_SLIP_HOLDOFF_EN, honour every i_slip that arrives with o_valid=1 and not build the holdoff counter.

Structure
REQ-026 SHALL take W_RX_WORD=32, W_BLK=66 and a default SLIP_HOLDOFF constant from package eth_pcs_params; W_SYNC, SYNC_CTRL and SYNC_DATA come from the existing entries.
REQ-027 SHALL be a single module with no sub-module; its outputs feed the RX block-sync stage directly (o_valid to its i_valid, o_sync_hdr to its i_sync_hdr, its o_slip back to i_slip).

Verification
REQ-028 SHALL verify alignment: feed continuous aligned 66-bit blocks with header 2'b01 and data 64'h0123_4567_89AB_CDEF -> every o_valid shows o_sync_hdr=2'b01 and that data; 32 o_valid pulses per 66 input words.
REQ-029 SHALL verify slip search: stream offset by 5 bits with a block-sync model in the loop -> exactly 5 honoured slips, after which the headers stay valid (macro off).
REQ-030 SHALL verify slip with zero residual: force cnt=0 at o_valid and assert i_slip -> slip_pending=1; the next word's bit 0 is dropped and the following block is shifted by one bit.
REQ-031 SHALL verify holdoff: macro on, SLIP_HOLDOFF=4, assert i_slip on every o_valid -> a slip is honoured on blocks 1, 6, 11, and so on.
REQ-032 SHALL verify input gaps: insert i_valid=0 gaps of 1-7 cycles -> block content is identical to the gapless run and o_valid occurs only after a completing word.
REQ-033 SHALL verify mid-operation reset: assert i_reset after 40 bits of a block -> outputs 0 the next cycle, and the first post-reset word is taken as block bit 0.

Source files
------------

// File: rtl/eth_pcs_params.sv
// eth_pcs_params: shared widths and constants for the Ethernet PCS receive path.
package eth_pcs_params;

  // SerDes word width; bit 0 is the earliest received bit.
  localparam int W_RX_WORD = 32;
  // 64b/66b block width.
  localparam int W_BLK = 66;
  // Sync header width and the two legal header values.
  localparam int W_SYNC = 2;
  localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b10;
  localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;
  // Default number of blocks during which slips are ignored after a slip.
  localparam int SLIP_HOLDOFF_DEFAULT = 4;

  // Gearbox buffer: a residual of up to W_BLK-1 bits plus one full word.
  localparam int W_BUF = W_BLK + W_RX_WORD - 1;
  // Bit count 0..W_BUF.
  localparam int W_CNT = $clog2(W_BUF + 1);

  // True for either legal sync header.
  function automatic logic is_valid_hdr(input logic [W_SYNC-1:0] hdr);
    return (hdr == SYNC_CTRL) || (hdr == SYNC_DATA);
  endfunction

endpackage

// File: rtl/eth_pcs_rx_gearbox.sv
// eth_pcs_rx_gearbox: re-packs 32-bit SerDes words into 66-bit PCS blocks and
// shifts the block boundary one bit per honoured i_slip.
// Build option: ETH_PCS_RX_GEARBOX_SLIP_HOLDOFF_EN ignores i_slip for
// SLIP_HOLDOFF o_valid blocks after each honoured slip.
// Handshake: there is no back-pressure. i_valid qualifies i_data for exactly
// the edge it is high on; o_valid is a one-cycle pulse qualifying o_sync_hdr
// and o_data, which keep their last value while o_valid is low.
module eth_pcs_rx_gearbox
  import eth_pcs_params::*;
#(
  parameter int SLIP_HOLDOFF = SLIP_HOLDOFF_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic [W_RX_WORD-1:0] i_data,
  input  logic                 i_slip,
  output logic                 o_valid,
  output logic [W_SYNC-1:0]    o_sync_hdr,
  output logic [63:0]          o_data
);

  // Bit buffer (bit 0 = stream head); bits at and above cnt_q are always zero.
  logic [W_BUF-1:0] buf_q, buf_d;
  logic [W_CNT-1:0] cnt_q, cnt_d;
  // A slip arrived with an empty buffer: drop the first bit of the next word.
  logic             pend_q, pend_d;
  logic             vld_q, vld_d;
  logic [W_BLK-1:0] blk_q, blk_d;
  logic [W_BUF-1:0] word_ext;
  logic             slip_take;

`ifdef ETH_PCS_RX_GEARBOX_SLIP_HOLDOFF_EN
  localparam int HOLD_W = (SLIP_HOLDOFF < 2) ? 1 : $clog2(SLIP_HOLDOFF + 1);
  logic [HOLD_W-1:0] hold_q, hold_d;

  // Slips are taken only on a block pulse, outside a pending drop and holdoff.
  assign slip_take = i_slip && vld_q && !pend_q && (hold_q == '0);

  // Holdoff counter: loaded on a taken slip, counts down once per block pulse.
  always_comb begin
    hold_d = hold_q;
    if (slip_take) begin
      hold_d = HOLD_W'(SLIP_HOLDOFF);
    end else if (vld_q && (hold_q != '0)) begin
      hold_d = hold_q - 1'b1;
    end
  end

  // Holdoff counter register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  // Slips are taken only on a block pulse and outside a pending drop.
  assign slip_take = i_slip && vld_q && !pend_q;

  // The holdoff depth has no effect in this build.
  logic unused_holdoff;
  assign unused_holdoff = ^SLIP_HOLDOFF;
`endif

  // Datapath: append the word, extract a full block, then apply the slip.
  always_comb begin
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    vld_d    = 1'b0;
    blk_d    = blk_q;
    word_ext = '0;

    if (i_valid) begin
      if (pend_q) begin
        word_ext = W_BUF'(i_data[W_RX_WORD-1:1]);
        cnt_d    = cnt_q + W_CNT'(W_RX_WORD - 1);
        pend_d   = 1'b0;
      end else begin
        word_ext = W_BUF'(i_data);
        cnt_d    = cnt_q + W_CNT'(W_RX_WORD);
      end
      word_ext = word_ext << cnt_q;
      buf_d    = buf_q | word_ext;
    end

    if (cnt_d >= W_CNT'(W_BLK)) begin
      vld_d = 1'b1;
      blk_d = buf_d[W_BLK-1:0];
      buf_d = buf_d >> W_BLK;
      cnt_d = cnt_d - W_CNT'(W_BLK);
    end

    if (slip_take) begin
      if (cnt_d != '0) begin
        buf_d = buf_d >> 1;
        cnt_d = cnt_d - 1'b1;
      end else begin
        pend_d = 1'b1;
      end
    end
  end

  // State and output registers; reset wins over any input activity.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      buf_q  <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      vld_q  <= 1'b0;
      blk_q  <= '0;
    end else begin
      buf_q  <= buf_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      vld_q  <= vld_d;
      blk_q  <= blk_d;
    end
  end

  assign o_valid    = vld_q;
  assign o_sync_hdr = blk_q[W_SYNC-1:0];
  assign o_data     = blk_q[W_BLK-1:W_SYNC];

endmodule

// File: tb/tb_eth_pcs_rx_gearbox.sv
// tb_eth_pcs_rx_gearbox: directed bench for the 32->66 RX gearbox.
// The expected blocks come from a bit-stream model: the bench keeps the whole
// transmitted stream and the absolute stream position of the next block start.
`timescale 1ns/1ps
module tb_eth_pcs_rx_gearbox;
  import eth_pcs_params::*;

  localparam int HOLD = 4;
  localparam logic [65:0] ALIGN_BLK = {64'h0123_4567_89AB_CDEF, 2'b01};
  localparam logic [65:0] SEARCH_BLK = {64'hFEDC_BA98_7654_3210, 2'b01};

  // ---------------- clock / reset / DUT ----------------
  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_valid = 1'b0;
  logic [31:0] i_data = '0;
  logic        i_slip = 1'b0;
  logic        o_valid;
  logic [1:0]  o_sync_hdr;
  logic [63:0] o_data;

  eth_pcs_rx_gearbox #(.SLIP_HOLDOFF(HOLD)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .i_slip     (i_slip),
    .o_valid    (o_valid),
    .o_sync_hdr (o_sync_hdr),
    .o_data     (o_data)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- scoreboard state ----------------
  int          errors = 0;
  int          checks = 0;
  logic [65:0] exp_q[$];
  bit          stream [0:4095];
  int          tot;        // stream bits delivered to the DUT
  int          blk;        // stream position of the next block start
  int          hold;       // model holdoff counter
  int          honours;    // slips the model expects to be taken
  int          pulses;     // o_valid pulses seen
  bit          ev_prev;    // model o_valid for the current cycle
  logic [65:0] last_blk;   // last block the outputs should be holding

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic model_clear();
    tot      = 0;
    blk      = 0;
    hold     = 0;
    honours  = 0;
    pulses   = 0;
    ev_prev  = 1'b0;
    last_blk = '0;
    exp_q.delete();
  endtask

  // Reset edge with optional activity on the other inputs; outputs must be 0.
  task automatic do_reset(input bit v, input bit s);
    i_reset = 1'b1;
    i_valid = v;
    i_slip  = s;
    i_data  = $urandom;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    i_valid = 1'b0;
    i_slip  = 1'b0;
    model_clear();
    check("rst_valid", o_valid, 0);
    check("rst_hdr", o_sync_hdr, 0);
    check("rst_data", o_data, 0);
  endtask

  // One clock: drive the next stream word if v, the slip request s; then check.
  task automatic step(input bit v, input bit s);
    logic [31:0] w;
    logic [65:0] e;
    bit          pend;
    bit          take;
    bit          ev;
    w = $urandom;
    if (v) for (int k = 0; k < 32; k++) w[k] = stream[tot + k];
    pend = (blk > tot);
    take = s && ev_prev && !pend;
`ifdef ETH_PCS_RX_GEARBOX_SLIP_HOLDOFF_EN
    take = take && (hold == 0);
`endif
    i_valid = v;
    i_data  = w;
    i_slip  = s;
    @(posedge i_clk);
    if (v) tot += 32;
    ev = 1'b0;
    if (tot - blk >= 66) begin
      ev = 1'b1;
      for (int k = 0; k < 66; k++) e[k] = stream[blk + k];
      exp_q.push_back(e);
      blk += 66;
    end
`ifdef ETH_PCS_RX_GEARBOX_SLIP_HOLDOFF_EN
    if (take) hold = HOLD;
    else if (ev_prev && hold > 0) hold--;
`endif
    if (take) begin
      blk++;
      honours++;
    end
    #1;
    i_valid = 1'b0;
    i_slip  = 1'b0;
    check("o_valid", o_valid, ev);
    if (o_valid) pulses++;
    if (ev) begin
      last_blk = exp_q.pop_front();
      check("block", {o_data, o_sync_hdr}, last_blk);
    end else begin
      check("held_block", {o_data, o_sync_hdr}, last_blk);
    end
    ev_prev = ev;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 4096; i++) stream[i] = bit'($urandom_range(0, 1));
  endtask

  task automatic fill_blocks(input logic [65:0] b, input int prefix);
    for (int i = 0; i < prefix; i++) stream[i] = 1'b1;
    for (int i = prefix; i < 4096; i++) stream[i] = b[(i - prefix) % 66];
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [65:0] hand;
    int          req_slips;
    int          n;
    bit          s;

    // Reset state.
    do_reset(1'b0, 1'b0);

    // Aligned blocks: constant content, 32 pulses per 66 words.
    fill_blocks(ALIGN_BLK, 0);
    for (int i = 0; i < 66; i++) begin
      step(1'b1, 1'b0);
      if (o_valid) begin
        check("align_hdr", o_sync_hdr, 2'b01);
        check("align_data", o_data, 64'h0123_4567_89AB_CDEF);
      end
    end
    check("align_pulses", pulses, 32);

    // Input gaps of 1..7 idle cycles between words.
    do_reset(1'b0, 1'b0);
    fill_random();
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0);
      n = $urandom_range(1, 7);
      for (int g = 0; g < n; g++) step(1'b0, 1'b0);
    end
    check("gap_pulses", pulses, 19);

    // Slip with an empty buffer: 33 words leave zero residual after block 16.
    do_reset(1'b0, 1'b0);
    fill_random();
    for (int i = 0; i < 33; i++) step(1'b1, 1'b0);
    check("zr_pulses", pulses, 16);
    step(1'b0, 1'b1);
    check("zr_honour", honours, 1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    for (int k = 0; k < 66; k++) hand[k] = stream[1057 + k];
    check("zr_valid", o_valid, 1);
    check("zr_block", {o_data, o_sync_hdr}, hand);

`ifdef ETH_PCS_RX_GEARBOX_SLIP_HOLDOFF_EN
    // Holdoff: slip requested on every cycle; taken on blocks 1, 6, 11.
    do_reset(1'b0, 1'b0);
    fill_blocks(ALIGN_BLK, 0);
    n = 0;
    while (pulses < 12 && n < 60) begin
      step(1'b1, 1'b1);
      n++;
    end
    check("hold_pulses", pulses, 12);
    check("hold_honours", honours, 3);
`else
    // Slip search: stream offset by 5 bits, block-sync decision in the loop.
    do_reset(1'b0, 1'b0);
    fill_blocks(SEARCH_BLK, 5);
    s = 1'b0;
    req_slips = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, s);
      s = o_valid && !is_valid_hdr(o_sync_hdr);
      if (s) req_slips++;
    end
    check("search_slips", req_slips, 5);
    check("search_honours", honours, 5);
    check("search_last_hdr", o_sync_hdr, 2'b01);
    check("search_last_data", o_data, 64'hFEDC_BA98_7654_3210);
`endif

    // Mid-block reset: 26 words leave 40 residual bits, then reset with
    // valid and slip asserted; the next word must start a new block.
    do_reset(1'b0, 1'b0);
    fill_random();
    for (int i = 0; i < 26; i++) step(1'b1, 1'b0);
    do_reset(1'b1, 1'b1);
    fill_random();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    for (int k = 0; k < 66; k++) hand[k] = stream[k];
    check("post_rst_valid", o_valid, 1);
    check("post_rst_block", {o_data, o_sync_hdr}, hand);

    check("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
